// File: rtl/shadow_pkg.sv
// Shared FSM encoding and default geometry for the shadow chain receiver.
package shadow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DUMP  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/shadow_word_fifo.sv
// Synchronous word FIFO with full/empty flags; a push while full succeeds only if a pop occurs in the same cycle.
module shadow_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observable through cnt_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/shadow_chain_rx.sv
// Shadow capture chain deserializer: enables a chain dump, packs bits LSB first into words, queues them in a FIFO.
// Optional macro SHADOW_CHAIN_RX_PARITY_EN adds a running XOR of accepted bits on rx_parity.
module shadow_chain_rx
    import shadow_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic              sh_clk,
    input  logic              sh_rst,
    input  logic              start,
    output logic              dump_en,
    input  logic              ch_in,
    input  logic              ch_in_vld,
    input  logic              ch_in_done,
    output logic [WORD_W-1:0] word_data,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic [CNT_W-1:0]  bit_count,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              rx_parity,
    output state_e            dbg_state
);

    // Handshake: a word transfers on any cycle with word_vld && word_rdy; word_vld
    // never drops without a transfer, and word_data holds steady while word_vld is high.

    localparam int PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [PW-1:0] LAST_POS = PW'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] with_bit;
    logic              push_req, fifo_push, word_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] push_data;

    assign word_vld  = !fifo_empty;
    assign word_pop  = word_vld && word_rdy;
    assign fifo_push = push_req && (!fifo_full || word_pop);
    assign dump_en   = (state_q == ST_DUMP);
    assign busy      = (state_q == ST_DUMP) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign overflow  = ovf_q;
    assign bit_count = cnt_q;
    assign dbg_state = state_q;

    always_comb begin
        with_bit        = shreg_q;
        with_bit[pos_q] = ch_in;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        shreg_d   = shreg_q;
        ovf_d     = ovf_q;
        push_req  = 1'b0;
        push_data = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    pos_d   = '0;
                    shreg_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (ch_in_vld) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (pos_q == LAST_POS) begin
                        push_req  = 1'b1;
                        push_data = with_bit;
                        shreg_d   = '0;
                        pos_d     = '0;
                    end else begin
                        shreg_d = with_bit;
                        pos_d   = pos_q + 1'b1;
                    end
                end
                if (ch_in_done) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Upper bits of shreg_q are already zero, giving the padded partial word.
                push_req = (pos_q != '0);
                shreg_d  = '0;
                pos_d    = '0;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (push_req && fifo_full && !word_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            shreg_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            shreg_q <= shreg_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SHADOW_CHAIN_RX_PARITY_EN
    logic par_q;

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            par_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            par_q <= 1'b0;
        end else if (state_q == ST_DUMP && ch_in_vld) begin
            par_q <= par_q ^ ch_in;
        end
    end

    assign rx_parity = par_q;
`else
    assign rx_parity = 1'b0;
`endif

    shadow_word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sh_clk),
        .rst_i   (sh_rst),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .pop_i   (word_pop),
        .data_o  (word_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_shadow_chain_rx.sv
// Directed bench for shadow_chain_rx: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_shadow_chain_rx;
    import shadow_pkg::*;

    logic        sh_clk;
    logic        sh_rst;
    logic        start;
    logic        dump_en;
    logic        ch_in;
    logic        ch_in_vld;
    logic        ch_in_done;
    logic [31:0] word_data;
    logic        word_vld;
    logic        word_rdy;
    logic [15:0] bit_count;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        rx_parity;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    shadow_chain_rx dut (
        .sh_clk     (sh_clk),
        .sh_rst     (sh_rst),
        .start      (start),
        .dump_en    (dump_en),
        .ch_in      (ch_in),
        .ch_in_vld  (ch_in_vld),
        .ch_in_done (ch_in_done),
        .word_data  (word_data),
        .word_vld   (word_vld),
        .word_rdy   (word_rdy),
        .bit_count  (bit_count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .rx_parity  (rx_parity),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial sh_clk = 1'b0;
    always #5 sh_clk = ~sh_clk;

    // monitor: a word counts as taken when vld && rdy ahead of the next rising edge
    always @(negedge sh_clk) begin
        if (!sh_rst && word_vld && word_rdy) got_q.push_back(word_data);
        if (!sh_rst && done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sh_clk);
        #1;
    endtask

    task automatic do_start();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic last);
        ch_in      = b;
        ch_in_vld  = 1'b1;
        ch_in_done = last;
        tick();
        ch_in_vld  = 1'b0;
        ch_in_done = 1'b0;
        ch_in      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic end_dump();
        ch_in_done = 1'b1;
        tick();
        ch_in_done = 1'b0;
    endtask

    task automatic wait_idle_drain(input int drain);
        for (int i = 0; i < 20 && dbg_state != ST_IDLE; i++) tick();
        check_eq("idle_timeout", 64'(dbg_state), 64'(ST_IDLE));
        repeat (drain) tick();
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        sh_rst = 1'b1; start = 1'b0; ch_in = 1'b0; ch_in_vld = 1'b0;
        ch_in_done = 1'b0; word_rdy = 1'b1;
        repeat (3) tick();
        sh_rst = 1'b0;
        tick();

        // reset state
        check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check_eq("rst_dump_en", 64'(dump_en), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_vld", 64'(word_vld), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_cnt", 64'(bit_count), 64'd0);
        check_eq("rst_par", 64'(rx_parity), 64'd0);

        // two full words then done
        do_start();
        check_eq("t1_dump_en", 64'(dump_en), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd1);
        exp_q.push_back(32'hA5A5_A5A5);
        exp_q.push_back(32'h0000_FFFF);
        send_word(32'hA5A5_A5A5);
        send_word(32'h0000_FFFF);
        end_dump();
        check_eq("t1_flush_busy", 64'(busy), 64'd1);
        check_eq("t1_flush_dump_en", 64'(dump_en), 64'd0);
        wait_idle_drain(6);
        check_words("t1");
        check_eq("t1_cnt", 64'(bit_count), 64'd64);
        check_eq("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("t1_ovf", 64'(overflow), 64'd0);

        // partial word 1,0,1,1,1
        do_start();
        exp_q.push_back(32'h0000_001D);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        end_dump();
        wait_idle_drain(4);
        check_words("t2");
        check_eq("t2_cnt", 64'(bit_count), 64'd5);
        check_eq("t2_done_cnt", 64'(done_cnt), 64'd1);

        // overflow: six words into a four-deep FIFO with no consumer
        word_rdy = 1'b0;
        do_start();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) exp_q.push_back(32'h1111_1111 * k);
            send_word(32'h1111_1111 * k);
        end
        end_dump();
        wait_idle_drain(2);
        check_eq("t3_ovf", 64'(overflow), 64'd1);
        check_eq("t3_vld", 64'(word_vld), 64'd1);
        check_eq("t3_cnt", 64'(bit_count), 64'd192);
        word_rdy = 1'b1;
        repeat (6) tick();
        check_words("t3");
        check_eq("t3_vld_empty", 64'(word_vld), 64'd0);
        check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);

        // done together with bit 32: one word, no partial
        do_start();
        check_eq("t4_ovf_cleared", 64'(overflow), 64'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < 31; i++) send_bit(1'(32'hDEAD_BEEF >> i), 1'b0);
        send_bit(1'b1, 1'b1);
        check_eq("t4_state_flush", 64'(dbg_state), 64'(ST_FLUSH));
        wait_idle_drain(4);
        check_words("t4");
        check_eq("t4_cnt", 64'(bit_count), 64'd32);

        // reset mid-dump, then a clean dump
        do_start();
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        check_eq("t5_pre_cnt", 64'(bit_count), 64'd10);
        sh_rst = 1'b1;
        #1;
        check_eq("t5_state", 64'(dbg_state), 64'(ST_IDLE));
        check_eq("t5_dump_en", 64'(dump_en), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_cnt", 64'(bit_count), 64'd0);
        check_eq("t5_vld", 64'(word_vld), 64'd0);
        check_eq("t5_ovf", 64'(overflow), 64'd0);
        tick();
        sh_rst = 1'b0;
        repeat (3) tick();
        check_eq("t5_stay_idle", 64'(dbg_state), 64'(ST_IDLE));
        do_start();
        exp_q.push_back(32'h0000_0003);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        end_dump();
        wait_idle_drain(4);
        check_words("t5");
        check_eq("t5_new_cnt", 64'(bit_count), 64'd3);

        // parity over seven one-bits
        do_start();
        exp_q.push_back(32'h0000_007F);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        end_dump();
        wait_idle_drain(4);
        check_words("t6");
`ifdef SHADOW_CHAIN_RX_PARITY_EN
        check_eq("t6_parity", 64'(rx_parity), 64'd1);
`else
        check_eq("t6_parity", 64'(rx_parity), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shadow_chain_rx.md
SHADOW_CHAIN_RX -- requirements
Module: shadow_chain_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 32, the width of each deserialized output word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of output word entries (power of two).
REQ-003 SHALL have parameter CNT_W, default 16, the width of the received-bit counter.
REQ-004 SHALL have port sh_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port sh_rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a dump; ignored unless IDLE.
REQ-007 SHALL have port dump_en, output, 1, the dump enable driven to the shadow capture chain.
REQ-008 SHALL have port ch_in, input, 1, the serial chain data bit.
REQ-009 SHALL have port ch_in_vld, input, 1, which qualifies ch_in.
REQ-010 SHALL have port ch_in_done, input, 1, chain-finished indication.
REQ-011 SHALL have ports word_data (output, WORD_W), word_vld (output, 1) and word_rdy (input, 1), forming the output FIFO head with a valid/ready handshake.
REQ-012 SHALL have port bit_count, output, CNT_W, the number of bits received in the current or last dump.
REQ-013 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and overflow (output, 1, sticky).

Function
REQ-014 SHALL implement FSM states IDLE, DUMP, FLUSH and DONE.
REQ-015 SHALL, in IDLE with start=1, clear bit_count, the shift register and overflow, then enter DUMP the next cycle.
REQ-016 SHALL assert dump_en=1 and busy=1 exactly while in DUMP; busy SHALL also be 1 in FLUSH.
REQ-017 SHALL, in DUMP with ch_in_vld=1, store ch_in at bit position bit_count mod WORD_W (LSB first) and increment bit_count, saturating at all-ones.
REQ-018 SHALL, when the bit completing a word (position WORD_W-1) is accepted, push the word into the FIFO in the same cycle; the word becomes visible on word_vld in the following cycle.
REQ-019 SHALL, if a push is required while the FIFO is full, drop that word and set overflow; overflow SHALL remain set until the next start or reset.
REQ-020 SHALL, on ch_in_done=1 in DUMP, go to FLUSH; if ch_in_vld is also 1 in that cycle, SHALL accept the bit first.
REQ-021 SHALL, in FLUSH, push the partial word zero-padded in the upper bits if bit_count mod WORD_W != 0, or push nothing otherwise, then go to DONE; a full FIFO in this cycle follows REQ-019.
REQ-022 SHALL, in DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-023 SHALL ignore ch_in_vld and ch_in_done outside DUMP.
REQ-024 SHALL pop the FIFO on word_vld and word_rdy both 1; a simultaneous push and pop when the FIFO is full SHALL succeed without overflow.
REQ-025 SHALL allow FIFO pops in every state, including IDLE after a dump.

Reset
REQ-026 SHALL, on sh_rst=1, immediately force the FSM to IDLE and set dump_en=0, busy=0, done=0, word_vld=0, overflow=0 and bit_count=0, and empty the FIFO; the partial word SHALL be discarded.
REQ-027 SHALL, when reset is asserted mid-dump, resume from IDLE only on a new start after reset deassertion.

Configuration
REQ-028 SHALL, with SHADOW_CHAIN_RX_PARITY_EN defined, provide an output rx_parity that is the XOR of all accepted bits since start, updated with each accepted bit and reset to 0.
REQ-029 SHALL, without SHADOW_CHAIN_RX_PARITY_EN, tie rx_parity to 0 and contain no parity logic.

Structure
REQ-030 SHALL take the FSM state encoding and the default WORD_W/FIFO_DEPTH constants from shared package shadow_pkg.
REQ-031 SHALL implement the FIFO as sub-module shadow_word_fifo (synchronous, full/empty flags, async active-high reset).

Verification
REQ-032 SHALL cover: start, 64 bits of 0xA5A5A5A5 then 0x0000FFFF, then ch_in_done -> two words in that order, bit_count=64, done pulses once.
REQ-033 SHALL cover: 5 bits 1,0,1,1,1 then done (WORD_W=32) -> one word 0x0000001D, bit_count=5.
REQ-034 SHALL cover: word_rdy=0 and 6 full words sent (FIFO_DEPTH=4) -> 4 words retained (first four), overflow=1 until the next start.
REQ-035 SHALL cover: ch_in_vld=1 and ch_in_done=1 in the same cycle on bit 32 -> bit accepted, one word pushed, no partial word.
REQ-036 SHALL cover: sh_rst asserted after 10 bits -> all outputs return to reset values immediately; a new start yields a clean dump.
REQ-037 SHALL cover, with SHADOW_CHAIN_RX_PARITY_EN defined: 7 one-bits -> rx_parity=1; without the macro -> rx_parity=0.
